// File: rtl/alu_mc.sv
// Registered W-bit ALU with valid/ready on both sides and a single-entry output register.
// Every opcode except multiply takes one cycle. Multiply is a W-cycle shift-add.
module alu_mc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [3:0]   opcode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [W-1:0] carry,
    output logic         zero,
    output logic         busy
);
    localparam int SHW = $clog2(W);
    localparam logic [SHW-1:0] LAST_BIT = SHW'(W - 1);
    localparam logic [3:0]     OP_MUL   = 4'b1000;

    // Handshake: a transfer happens on a rising edge where valid && ready on the same side.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2*W-1:0]   r_mcand;
    logic [W-1:0]     r_mplier;
    logic [2*W-1:0]   r_acc;
    logic [SHW-1:0]   r_cnt;
    logic [W-1:0]     r_result;
    logic [W-1:0]     r_carry;
    logic             r_zero;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [2*W-1:0]   w_acc_nxt;
    logic [W-1:0]     w_res;
    logic [W-1:0]     w_cry;
    logic [W:0]       w_sum;
    logic             w_zero;

    assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = (opcode == OP_MUL);
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == LAST_BIT);
    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign busy      = (r_state == S_MUL);

    // Single-cycle operations; multiply leaves these zero and is handled by the iterator.
    always_comb begin
        w_res = '0;
        w_cry = '0;
        w_sum = '0;
        case (opcode)
            4'b0000: w_res[0] = &A;
            4'b0001: w_res[0] = ^A;
            4'b0010: w_res[0] = |A;
            4'b0011: w_res = A & B;
            4'b0100: w_res = A | B;
            4'b0101: w_res = A ^ B;
            4'b0110: begin
                w_sum    = {1'b0, A} + {1'b0, B};
                w_res    = w_sum[W-1:0];
                w_cry[0] = w_sum[W];
            end
            4'b0111: begin
                w_sum    = {1'b0, A} - {1'b0, B};
                w_res    = w_sum[W-1:0];
                w_cry[0] = w_sum[W];
            end
            4'b1001: w_res[0] = (A == B);
            4'b1010: w_res[0] = (A > B);
            4'b1011: w_res[0] = (A < B);
            4'b1100: w_res = A >> B[SHW-1:0];
            4'b1101: w_res = A << B[SHW-1:0];
            4'b1110: w_res = A & ~B;
            4'b1111: w_res = ~A;
            default: w_res = '0;
        endcase
    end

    assign w_zero = (w_res == '0) && (w_cry == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:   if (w_mul_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Multiplicand shifts left and multiplier shifts right so bit 0 always selects the addend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= {{W{1'b0}}, A};
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_carry     <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_result    <= w_res;
            r_carry     <= w_cry;
            r_zero      <= w_zero;
            r_out_valid <= 1'b1;
        end else if (w_mul_done) begin
            r_result    <= w_acc_nxt[W-1:0];
            r_carry     <= w_acc_nxt[2*W-1:W];
            r_zero      <= (w_acc_nxt == '0);
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Registered, parametrised-width ALU with a valid/ready handshake on both sides.
- Keeps the team's 16-entry 4-bit opcode map: reductions, bitwise, add/sub/mul, compare, shift, clear, invert.
- All ops except multiply complete in one cycle. Multiply is an iterative shift-add over W cycles.
- Sits between an operand-issuing controller and a result consumer; a single-entry output register absorbs backpressure.

Parameters:
- W, 8, operand/result width; W >= 2, power of two.
- SHW, $clog2(W), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  block can accept this cycle
- A  input  W  operand A
- B  input  W  operand B
- opcode  input  4  operation select
- out_valid  output  1  result/carry/zero valid
- out_ready  input  1  consumer takes result this cycle
- result  output  W  low result word
- carry  output  W  carry/borrow in bit 0, or multiply high word
- zero  output  1  result==0 and carry==0
- busy  output  1  multiply in progress

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result=0, carry=0, zero=0, out_valid=0, busy=0; multiply iteration counter and partial product cleared; in_ready=1 once reset releases.
- Reset mid-multiply aborts the operation. No result is ever produced for it.
- States:
  - IDLE: accepts operations.
  - MUL: iterating; busy=1, in_ready=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready at a rising edge.
- Non-multiply accept: result, carry and zero are registered at the accepting edge; out_valid=1 from the next cycle. Latency is 1. Back-to-back accepts are allowed every cycle while out_ready=1.
- Multiply accept (opcode 1000):
  - At the accepting edge: load A and B, clear the 2W-bit accumulator, counter=0, go to MUL.
  - Each MUL edge processes one multiplier bit, LSB first.
  - At the W-th MUL edge: {carry,result}=A*B (full 2W bits), out_valid=1, state=IDLE.
  - out_valid therefore rises W edges after the accept.
  - No collision is possible: the output register was free or draining at accept, and out_valid stays 0 throughout MUL.
- Output hold: while out_valid && !out_ready, result, carry and zero hold stable. out_valid falls on the edge where out_ready=1, unless a new non-multiply op is accepted on that same edge, in which case out_valid stays 1 with the new data.
- Opcode map. carry=0 and upper result bits=0 unless stated otherwise.
  - 0000 &A in bit 0
  - 0001 ^A in bit 0
  - 0010 |A in bit 0
  - 0011 A&B
  - 0100 A|B
  - 0101 A^B
  - 0110 {carry[0],result}=A+B (W+1 bits)
  - 0111 {carry[0],result}=A-B (W+1 bits); carry[0]=1 on borrow (A<B)
  - 1000 multiply (above)
  - 1001 A==B in bit 0
  - 1010 A>B (unsigned) in bit 0
  - 1011 A<B (unsigned) in bit 0
  - 1100 A>>B[SHW-1:0], logical, truncated to W bits
  - 1101 A<<B[SHW-1:0], truncated to W bits; shifted-out bits are lost
  - 1110 A&~B
  - 1111 ~A
- Upper bits of B beyond SHW are ignored for shifts.
- All 16 opcodes are defined; there is no error path.
- zero is computed from the final registered {carry,result}.
- in_valid while in_ready=0 is ignored. The producer must hold its inputs until accepted.
- Operands are captured at accept; input changes during MUL have no effect.

Test Plan (W=8):
- Reset release, then add A=200 B=100 -> next cycle out_valid=1, result=44, carry=1, zero=0.
- Sub A=5 B=7 -> result=254, carry[0]=1. Sub A=9 B=9 -> result=0, carry=0, zero=1.
- Mul A=255 B=255 -> busy=1 and in_ready=0 for 8 cycles; out_valid rises exactly 8 edges after accept with carry=0xFE, result=0x01. A second op presented during MUL is not accepted until the multiply completes.
- Backpressure: out_ready=0, issue xor A=0xF0 B=0x3C -> result=0xCC held, in_ready=0 for many cycles. Raise out_ready together with a new op (inv A=0x0F) -> out_valid stays 1, result=0xF0 next cycle.
- Shifts: 1101 A=0x81 B=9 -> result=0x02, carry=0 (B[2:0]=1). 1100 A=0x80 B=7 -> result=0x01.
- Assert rst_n=0 on the 4th MUL cycle -> all outputs 0 immediately. After release in_ready=1, and no stale out_valid appears.
